// File: rtl/move_sequencer.sv
// Per-frame object position sequencer: proposes one candidate move per frame_tick, commits or rejects it on the collision flags.
// Latency: frame_tick at T, commit at T+3+SETTLE (edge reject finishes at T+2); with MOVE_DIAG_EN each active axis takes its own phase.
// Backpressure: frame_tick while busy is dropped and sets sticky overrun; MOVE_DIAG_EN resolves x then y in the same frame.
module move_sequencer #(
    parameter int X_INIT  = 20,
    parameter int Y_INIT  = 20,
    parameter int STEP    = 2,
    parameter int TAMANHO = 20,
    parameter int SETTLE  = 2,
    parameter int X_MAX   = 640,
    parameter int Y_MAX   = 480
) (
    input  logic       VGA_clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       key_down,
    input  logic       key_up,
    input  logic       colisao_max_x,
    input  logic       colisao_min_x,
    input  logic       colisao_max_y,
    input  logic       colisao_min_y,
    output logic [9:0] cand_x,
    output logic [8:0] cand_y,
    output logic [6:0] tamanho,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       busy,
    output logic       blocked,
    output logic       overrun
);

    typedef enum logic [1:0] {S_IDLE, S_PROPOSE, S_WAIT, S_DECIDE} state_t;
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_DOWN, D_UP} dir_t;

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] TAM11  = 11'(TAMANHO);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);

    state_t     state_q, state_d;
    logic [3:0] keys_q, keys_d;
    logic [2:0] cnt_q, cnt_d;
    logic       reject_q, reject_d;
    logic [9:0] xpos_q, xpos_d, candx_q, candx_d;
    logic [8:0] ypos_q, ypos_d, candy_q, candy_d;
    logic       overrun_q, overrun_d;
`ifdef MOVE_DIAG_EN
    logic       phase_q, phase_d;
`endif

    logic [3:0] req_live, req_q;
    dir_t       dir;
    logic       edge_bad;
    logic       sel_flag;
    logic [10:0] x11, y11;

    // Key order {right,left,down,up}; an opposing pair pressed together cancels its axis.
    function automatic logic [3:0] axis_req(input logic [3:0] k);
        return {k[3] & ~k[2], k[2] & ~k[3], k[1] & ~k[0], k[0] & ~k[1]};
    endfunction

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            keys_q    <= 4'b0;
            cnt_q     <= 3'd0;
            reject_q  <= 1'b0;
            xpos_q    <= 10'(X_INIT);
            ypos_q    <= 9'(Y_INIT);
            candx_q   <= 10'(X_INIT);
            candy_q   <= 9'(Y_INIT);
            overrun_q <= 1'b0;
`ifdef MOVE_DIAG_EN
            phase_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            keys_q    <= keys_d;
            cnt_q     <= cnt_d;
            reject_q  <= reject_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            candx_q   <= candx_d;
            candy_q   <= candy_d;
            overrun_q <= overrun_d;
`ifdef MOVE_DIAG_EN
            phase_q   <= phase_d;
`endif
        end
    end

    always_comb begin
        req_live = axis_req({key_right, key_left, key_down, key_up});
        req_q    = axis_req(keys_q);
        x11      = {1'b0, xpos_q};
        y11      = {2'b0, ypos_q};
`ifdef MOVE_DIAG_EN
        if (!phase_q) dir = req_q[3] ? D_RIGHT : D_LEFT;
        else          dir = req_q[1] ? D_DOWN  : D_UP;
`else
        if      (req_q[3]) dir = D_RIGHT;
        else if (req_q[2]) dir = D_LEFT;
        else if (req_q[1]) dir = D_DOWN;
        else               dir = D_UP;
`endif
        case (dir)
            D_RIGHT: begin edge_bad = (x11 + STEP11 + TAM11) > XMAX11; sel_flag = colisao_max_x; end
            D_LEFT:  begin edge_bad = x11 < STEP11;                    sel_flag = colisao_min_x; end
            D_DOWN:  begin edge_bad = (y11 + STEP11 + TAM11) > YMAX11; sel_flag = colisao_max_y; end
            default: begin edge_bad = y11 < STEP11;                    sel_flag = colisao_min_y; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        keys_d    = keys_q;
        cnt_d     = cnt_q;
        reject_d  = reject_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        candx_d   = candx_q;
        candy_d   = candy_q;
        overrun_d = overrun_q | (frame_tick & (state_q != S_IDLE));
`ifdef MOVE_DIAG_EN
        phase_d   = phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                candx_d  = xpos_q;
                candy_d  = ypos_q;
                reject_d = 1'b0;
                if (frame_tick) begin
                    keys_d = {key_right, key_left, key_down, key_up};
`ifdef MOVE_DIAG_EN
                    if (|req_live[3:2]) begin
                        state_d = S_PROPOSE;
                        phase_d = 1'b0;
                    end else if (|req_live[1:0]) begin
                        state_d = S_PROPOSE;
                        phase_d = 1'b1;
                    end
`else
                    if (|req_live) state_d = S_PROPOSE;
`endif
                end
            end
            S_PROPOSE: begin
                if (edge_bad) begin
                    reject_d = 1'b1;
                    state_d  = S_DECIDE;
                end else begin
                    reject_d = 1'b0;
                    case (dir)
                        D_RIGHT: candx_d = xpos_q + 10'(STEP);
                        D_LEFT:  candx_d = xpos_q - 10'(STEP);
                        D_DOWN:  candy_d = ypos_q + 9'(STEP);
                        default: candy_d = ypos_q - 9'(STEP);
                    endcase
                    cnt_d   = 3'(SETTLE);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_DECIDE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DECIDE: begin
                if (!sel_flag && !reject_q) begin
                    xpos_d = candx_q;
                    ypos_d = candy_q;
                end else begin
                    candx_d = xpos_q;
                    candy_d = ypos_q;
                end
                reject_d = 1'b0;
                state_d  = S_IDLE;
`ifdef MOVE_DIAG_EN
                // y phase proposes from the position just committed by the x phase.
                if (!phase_q && |req_q[1:0]) begin
                    phase_d = 1'b1;
                    state_d = S_PROPOSE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        blocked = (state_q == S_DECIDE) && (reject_q || sel_flag);
    end

    assign cand_x  = candx_q;
    assign cand_y  = candy_q;
    assign xPos    = xpos_q;
    assign yPos    = ypos_q;
    assign overrun = overrun_q;
    assign tamanho = 7'(TAMANHO);

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: each frame move pushes its expected outcome, a negedge monitor checks it when busy drops.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       key_right, key_left, key_down, key_up;
    logic       colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y;
    logic [9:0] cand_x, xPos;
    logic [8:0] cand_y, yPos;
    logic [6:0] tamanho;
    logic       busy, blocked, overrun;

    typedef struct {
        int ex;
        int ey;
        int eblk;
        int elen;
        int emov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    move_sequencer dut (
        .VGA_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
        .colisao_max_x(colisao_max_x), .colisao_min_x(colisao_min_x),
        .colisao_max_y(colisao_max_y), .colisao_min_y(colisao_min_y),
        .cand_x(cand_x), .cand_y(cand_y), .tamanho(tamanho),
        .xPos(xPos), .yPos(yPos), .busy(busy), .blocked(blocked), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: accumulate per-move observations while busy, score on the falling edge of busy.
    int  m_len = 0, m_blk = 0, m_mov = 0, m_id = 0;
    logic m_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev = 1'b0;
            m_len = 0; m_blk = 0; m_mov = 0;
        end else begin
            if (busy) begin
                m_len++;
                if (blocked) m_blk++;
                if (cand_x != xPos || cand_y != yPos) m_mov = 1;
            end else begin
                check("blocked_while_idle", 32'(blocked), 32'd0);
            end
            if (m_prev && !busy) begin
                exp_t e;
                if (sb_q.size() == 0) begin
                    check($sformatf("m%0d_unexpected", m_id), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("m%0d_xPos", m_id),    32'(xPos),   32'(e.ex));
                    check($sformatf("m%0d_yPos", m_id),    32'(yPos),   32'(e.ey));
                    check($sformatf("m%0d_cand_x", m_id),  32'(cand_x), 32'(e.ex));
                    check($sformatf("m%0d_cand_y", m_id),  32'(cand_y), 32'(e.ey));
                    check($sformatf("m%0d_blocked", m_id), 32'(m_blk),  32'(e.eblk));
                    check($sformatf("m%0d_busy_len", m_id), 32'(m_len), 32'(e.elen));
                    check($sformatf("m%0d_cand_moved", m_id), 32'(m_mov), 32'(e.emov));
                end
                m_id++;
                m_len = 0; m_blk = 0; m_mov = 0;
            end
            m_prev = busy;
        end
    end

    task automatic set_keys(input logic [3:0] k);
        {key_right, key_left, key_down, key_up} = k;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    // Keys are flipped right after the tick to show the sampled request is what moves.
    task automatic do_move(input string nm, input logic [3:0] k,
                           input int ex, input int ey, input int eblk, input int elen, input int emov);
        exp_t e;
        e.ex = ex; e.ey = ey; e.eblk = eblk; e.elen = elen; e.emov = emov;
        sb_q.push_back(e);
        set_keys(k);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        set_keys(~k);
        wait_idle(nm);
        set_keys(4'b0);
    endtask

    localparam logic [3:0] K_R = 4'b1000, K_L = 4'b0100, K_D = 4'b0010, K_U = 4'b0001;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; set_keys(4'b0);
        {colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y} = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_xPos", 32'(xPos), 32'd20);
        check("rst_yPos", 32'(yPos), 32'd20);
        check("rst_cand_x", 32'(cand_x), 32'd20);
        check("rst_cand_y", 32'(cand_y), 32'd20);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_blocked", 32'(blocked), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("tamanho", 32'(tamanho), 32'd20);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_move("right", K_R, 22, 20, 0, 5, 1);
        do_move("left1", K_L, 20, 20, 0, 5, 1);
        do_move("left2", K_L, 18, 20, 0, 5, 1);
        for (int i = 0; i < 9; i++) do_move("left_run", K_L, 16 - 2 * i, 20, 0, 5, 1);
        do_move("left_edge", K_L, 0, 20, 1, 2, 0);

        colisao_max_y = 1'b1; colisao_max_x = 1'b1;
        do_move("down_coll", K_D, 0, 20, 1, 5, 1);
        colisao_max_y = 1'b0; colisao_max_x = 1'b0;

        do_move("cancel_x", K_R | K_L | K_U, 0, 18, 0, 5, 1);
        do_move("prio_r_d", K_R | K_D, 2, 18, 0, 5, 1);
        do_move("prio_l_du", K_L | K_D | K_U, 0, 18, 0, 5, 1);

        set_keys(K_D | K_U);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        set_keys(4'b0);
        for (int i = 0; i < 3; i++) begin
            check("nomove_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        check("nomove_xPos", 32'(xPos), 32'd0);
        check("nomove_yPos", 32'(yPos), 32'd18);

        colisao_min_y = 1'b1; colisao_max_x = 1'b1;
        do_move("up_coll", K_U, 0, 18, 1, 5, 1);
        colisao_min_y = 1'b0; colisao_max_x = 1'b0;

        for (int i = 0; i < 9; i++) do_move("up_run", K_U, 0, 16 - 2 * i, 0, 5, 1);
        do_move("up_edge", K_U, 0, 0, 1, 2, 0);
        do_move("down", K_D, 0, 2, 0, 5, 1);
        check("overrun_before", 32'(overrun), 32'd0);

        begin
            exp_t e;
            e.ex = 2; e.ey = 2; e.eblk = 0; e.elen = 5; e.emov = 1;
            sb_q.push_back(e);
            set_keys(K_R);
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            set_keys(K_L);
            @(posedge clk); #1;
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            wait_idle("overrun_move");
            set_keys(4'b0);
        end
        check("overrun_set", 32'(overrun), 32'd1);
        do_move("after_overrun", K_D, 2, 4, 0, 5, 1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        set_keys(K_R);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        set_keys(4'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_xPos", 32'(xPos), 32'd20);
        check("arst_yPos", 32'(yPos), 32'd20);
        check("arst_cand_x", 32'(cand_x), 32'd20);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_move("post_rst_right", K_R, 22, 20, 0, 5, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
